// File: rtl/task_uart_tx.sv
// task_uart_tx: buffered 8N1 UART transmitter for the task output stream.
// Bytes are queued as {last, data}; an optional terminator byte follows every
// byte tagged last, and queued frames go out back-to-back with no idle gap.
module task_uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter bit          APPEND_TERM = 1'b1,
  parameter logic [7:0]  TERM_BYTE   = 8'h0A
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  input  logic                             i_last,
  input  logic [7:0]                       i_data,
  output logic                             o_tx,
  output logic                             o_busy,
  output logic                             o_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_level
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and pointers; the extra pointer bit separates full from empty
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [8:0]    head_entry;

  // Transmit state
  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          term_pend;
  logic          baud_done;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Full is judged before any same-cycle pop, so a write while full is lost
  assign push       = i_valid && !fifo_full;
  assign head_entry = mem[rd_ptr[AW-1:0]];
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign o_busy     = (state != IDLE) || (o_level != '0);

  // Pop when idle with data waiting, or at the end of a stop bit with no terminator owed
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE) begin
        pop = 1'b1;
      end else if (state == STOP && baud_done && !term_pend) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO data array write port (no reset: contents are don't-care once pointers clear)
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {i_last, i_data};
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_level    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        o_level <= o_level + LVL_ONE;
      end else if (!push && pop) begin
        o_level <= o_level - LVL_ONE;
      end
      if (i_valid && fifo_full) begin
        o_overflow <= 1'b1;
      end
    end
  end

  // Serialiser FSM: start bit, 8 data bits LSB first, stop bit; o_tx is registered
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      term_pend <= 1'b0;
      o_tx      <= 1'b1;
    end else begin
      baud_cnt <= baud_done ? '0 : baud_cnt + CNT_ONE;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          o_tx     <= 1'b1;
          if (pop) begin
            shift     <= head_entry[7:0];
            term_pend <= head_entry[8] & APPEND_TERM;
            o_tx      <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_done) begin
            bit_idx <= '0;
            o_tx    <= shift[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_done) begin
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              o_tx    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (baud_done) begin
            if (term_pend) begin
              // Terminator goes out before anything else that is queued
              shift     <= TERM_BYTE;
              term_pend <= 1'b0;
              o_tx      <= 1'b0;
              state     <= START;
            end else if (pop) begin
              shift     <= head_entry[7:0];
              term_pend <= head_entry[8] & APPEND_TERM;
              o_tx      <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule
